// File: rtl/input_pkg.sv
// Shared keypad geometry and key indexing, used by the scanner and the edge detector.
package input_pkg;

    localparam int KEY_ROWS  = 4;
    localparam int KEY_COLS  = 4;
    localparam int KEY_COUNT = KEY_ROWS * KEY_COLS;

    typedef logic [KEY_COUNT-1:0]        key_vec_t;
    typedef logic [$clog2(KEY_ROWS)-1:0] row_idx_t;

    // Flat bit position of the key at (row, col) in a key vector.
    function automatic int unsigned key_idx(input int unsigned row, input int unsigned col);
        return row * KEY_COLS + col;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; reset value is selectable
// so active-low inputs can come out of reset in their idle state.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with whole-frame debouncing, plus per-button
// debouncing of discrete push buttons. Outputs are clean synchronous levels.
module keypad_scanner
    import input_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int NUM_BUTTONS    = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [KEY_COLS-1:0]    col_in,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    output logic [KEY_ROWS-1:0]    row_out,
    output logic [KEY_COUNT-1:0]   keyboard,
    output logic [NUM_BUTTONS-1:0] button,
    output logic                   frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam row_idx_t         ROW_LAST = row_idx_t'(KEY_ROWS - 1);

    logic [KEY_COLS-1:0]    w_col_sync;
    logic [NUM_BUTTONS-1:0] w_btn_sync;
    logic                   w_sample;
    logic                   w_frame_end;
    key_vec_t               w_raw_next;
    logic                   w_frame_same;
    logic [CNT_W-1:0]       w_stable_next;

    logic [DIV_W-1:0]       r_dwell;
    row_idx_t               r_row;
    key_vec_t               r_raw_frame;
    key_vec_t               r_prev_frame;
    logic [CNT_W-1:0]       r_stable_cnt;
    key_vec_t               r_keyboard;
    logic [NUM_BUTTONS-1:0] r_button;
    logic [CNT_W-1:0]       r_btn_cnt [NUM_BUTTONS];
    logic                   r_frame_tick;

    // Columns idle high (pulled up), so their synchronizer resets to all ones.
    sync_2ff #(
        .WIDTH   (KEY_COLS),
        .RST_VAL ({KEY_COLS{1'b1}})
    ) u_sync_col (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (col_in),
        .o_q     (w_col_sync)
    );

    sync_2ff #(
        .WIDTH   (NUM_BUTTONS),
        .RST_VAL ('0)
    ) u_sync_btn (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (button_raw),
        .o_q     (w_btn_sync)
    );

    // Columns are sampled on the last dwell cycle so they have settled after the row change.
    assign w_sample    = (r_dwell == DIV_LAST);
    assign w_frame_end = w_sample && (r_row == ROW_LAST);

    // Drive exactly one row low; changes the cycle after the dwell counter wraps.
    assign row_out = ~({{(KEY_ROWS-1){1'b0}}, 1'b1} << r_row);

    // Raw frame with the current row's columns merged in, so the frame-end
    // evaluation sees row 3 in the same cycle it is sampled.
    always_comb begin
        w_raw_next = r_raw_frame;
        if (w_sample) begin
            for (int r = 0; r < KEY_ROWS; r++) begin
                if (r_row == row_idx_t'(r)) begin
                    w_raw_next[key_idx(r, 0) +: KEY_COLS] = ~w_col_sync;
                end
            end
        end
    end

    // A changed frame restarts the stability count at one; a repeat saturates it.
    always_comb begin
        w_frame_same  = (w_raw_next == r_prev_frame);
        w_stable_next = CNT_ONE;
        if (w_frame_same) begin
            w_stable_next = (r_stable_cnt == CNT_MAX) ? CNT_MAX : r_stable_cnt + CNT_ONE;
        end
    end

    // Dwell counter and row index; the row advances each time the dwell wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
            r_row   <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
            r_row   <= r_row + 1'b1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Capture the active row's inverted columns into the raw frame buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_raw_frame <= '0;
        end else if (w_sample) begin
            r_raw_frame <= w_raw_next;
        end
    end

    // One-cycle pulse marking the cycle in which a completed frame is committed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
        end
    end

    // Whole-frame debounce: the keyboard only updates at a frame end, once the
    // same frame has been seen DEBOUNCE_SCANS times in a row.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_frame <= '0;
            r_stable_cnt <= '0;
            r_keyboard   <= '0;
        end else if (w_frame_end) begin
            r_stable_cnt <= w_stable_next;
            if (!w_frame_same) begin
                r_prev_frame <= w_raw_next;
            end
            if (w_stable_next == CNT_MAX) begin
                r_keyboard <= w_raw_next;
            end
        end
    end

    // Per-button debounce: toggle after DEBOUNCE_SCANS consecutive frames of disagreement.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_button <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                r_btn_cnt[i] <= '0;
            end
        end else if (w_frame_end) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (w_btn_sync[i] != r_button[i]) begin
                    if (r_btn_cnt[i] == CNT_MAX - CNT_ONE) begin
                        r_button[i]  <= ~r_button[i];
                        r_btn_cnt[i] <= '0;
                    end else begin
                        r_btn_cnt[i] <= r_btn_cnt[i] + CNT_ONE;
                    end
                end else begin
                    r_btn_cnt[i] <= '0;
                end
            end
        end
    end

    assign keyboard   = r_keyboard;
    assign button     = r_button;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frame).
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  col_in;
    logic [4:0]  button_raw;
    logic [3:0]  row_out;
    logic [15:0] keyboard;
    logic [4:0]  button;
    logic        frame_tick;

    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .NUM_BUTTONS    (5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .col_in     (col_in),
        .button_raw (button_raw),
        .row_out    (row_out),
        .keyboard   (keyboard),
        .button     (button),
        .frame_tick (frame_tick)
    );

    // Row-aware keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] keys;
        logic [4:0]  btn;
        int          ticks;
        logic [15:0] exp_kb;
        logic [4:0]  exp_btn;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame_tick within 40 cycles", name);
        end
    endtask

    task automatic count_to_tick(input string name, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 40);
    endtask

    initial begin
        int          n;
        int          tick_cnt;
        logic        kb_moved;
        logic [3:0]  one;
        logic [3:0]  exp_row;

        vecs[0]  = '{16'h0200, 5'h00, 2, 16'h0000, 5'h00};
        vecs[1]  = '{16'h0200, 5'h00, 1, 16'h0200, 5'h00};
        vecs[2]  = '{16'h0000, 5'h00, 2, 16'h0200, 5'h00};
        vecs[3]  = '{16'h0000, 5'h00, 1, 16'h0000, 5'h00};
        vecs[4]  = '{16'h8001, 5'h10, 2, 16'h0000, 5'h00};
        vecs[5]  = '{16'h8001, 5'h10, 1, 16'h8001, 5'h10};
        vecs[6]  = '{16'h0000, 5'h00, 3, 16'h0000, 5'h00};
        vecs[7]  = '{16'hFFFF, 5'h1F, 3, 16'hFFFF, 5'h1F};
        vecs[8]  = '{16'h0000, 5'h00, 3, 16'h0000, 5'h00};
        vecs[9]  = '{16'h0000, 5'h01, 3, 16'h0000, 5'h01};
        vecs[10] = '{16'h0000, 5'h00, 3, 16'h0000, 5'h00};

        one        = 4'b0001;
        keys       = 16'h0000;
        button_raw = 5'h00;
        reset_n    = 1'b0;

        // Reset state and scan walk
        repeat (3) @(negedge clock);
        check16("rst_row", {12'h0, row_out}, 16'h000E);
        check16("rst_kb", keyboard, 16'h0000);
        check16("rst_btn", {11'h0, button}, 16'h0000);
        check16("rst_tick", {15'h0, frame_tick}, 16'h0000);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            exp_row = ~(one << ((k / 4) % 4));
            check16($sformatf("walk_row%0d", k), {12'h0, row_out}, {12'h0, exp_row});
            check16($sformatf("walk_tick%0d", k), {15'h0, frame_tick}, {15'h0, (k == 16)});
        end
        count_to_tick("period", n);
        check16("tick_period", 16'(n), 16'd16);

        // Table: single key press/release, combined keys+button, all keys, lone button
        for (int i = 0; i < NV; i++) begin
            keys       = vecs[i].keys;
            button_raw = vecs[i].btn;
            for (int t = 0; t < vecs[i].ticks; t++) wait_tick($sformatf("vec%0d_wait", i));
            check16($sformatf("vec%0d_kb", i), keyboard, vecs[i].exp_kb);
            check16($sformatf("vec%0d_btn", i), {11'h0, button}, {11'h0, vecs[i].exp_btn});
        end

        // Bounce on key (2,1): toggles every 5 cycles for 40 cycles, then held
        kb_moved = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            keys = ((cyc / 5) % 2 == 0) ? 16'h0200 : 16'h0000;
            if (keyboard != 16'h0000) kb_moved = 1'b1;
            @(negedge clock);
        end
        keys = 16'h0200;
        check16("bounce_hold", {15'h0, kb_moved}, 16'h0000);
        wait_tick("bounce_t1");
        wait_tick("bounce_t2");
        check16("bounce_t2_kb", keyboard, 16'h0000);
        wait_tick("bounce_t3");
        check16("bounce_t3_kb", keyboard, 16'h0200);

        keys = 16'h0000;
        wait_tick("rel_t1");
        wait_tick("rel_t2");
        check16("rel_t2_kb", keyboard, 16'h0200);
        wait_tick("rel_t3");
        check16("rel_t3_kb", keyboard, 16'h0000);

        // Glitch on key (0,0) for one frame only, over an 80-cycle window
        kb_moved = 1'b0;
        tick_cnt = 0;
        keys     = 16'h0001;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clock);
            if (cyc == 16) keys = 16'h0000;
            if (frame_tick) tick_cnt++;
            if (keyboard != 16'h0000) kb_moved = 1'b1;
        end
        check16("glitch_kb", {15'h0, kb_moved}, 16'h0000);
        check16("glitch_ticks", 16'(tick_cnt), 16'd5);

        // Reset mid-frame with a key committed
        keys = 16'h0200;
        wait_tick("pre_rst_t1");
        wait_tick("pre_rst_t2");
        wait_tick("pre_rst_t3");
        check16("pre_rst_kb", keyboard, 16'h0200);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check16("async_kb", keyboard, 16'h0000);
        check16("async_row", {12'h0, row_out}, 16'h000E);
        check16("async_btn", {11'h0, button}, 16'h0000);
        repeat (3) @(negedge clock);
        check16("held_rst_row", {12'h0, row_out}, 16'h000E);
        reset_n = 1'b1;
        count_to_tick("post_rst_t1", n);
        check16("post_rst_period", 16'(n), 16'd16);
        check16("post_rst_t1_kb", keyboard, 16'h0000);
        wait_tick("post_rst_t2");
        check16("post_rst_t2_kb", keyboard, 16'h0000);
        wait_tick("post_rst_t3");
        check16("post_rst_t3_kb", keyboard, 16'h0200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
